// File: rtl/keyin_pkg.sv
// rtl/keyin_pkg.sv - shared types and constants for the pixo_key_input PS/2 receiver
package keyin_pkg;

  // Register offsets on the CPU bus
  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  // STATUS register bit positions
  localparam int STAT_AVAIL = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_PERR  = 2;
  localparam int STAT_FULL  = 3;

  // CTRL register bit positions
  localparam int CTRL_CLR   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQE  = 2;

  // PS/2 frame receiver states
  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } frame_state_e;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchronisers, falling-edge sampler, frame FSM and timeout
module ps2_frame_rx
  import keyin_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Ps2Clk,
  input  logic       Ps2Data,
  output logic       ByteValid,
  output logic [7:0] ByteData,
  output logic       FrameErr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]   clk_sync_q;
  logic [1:0]   data_sync_q;
  logic         clk_prev_q;
  logic         fall;
  logic         bit_in;

  frame_state_e state_q, state_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [7:0]   byte_q, byte_d;

  // Two-flop synchronisers; lines idle high so they reset to 1 to avoid a false edge
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], Ps2Clk};
      data_sync_q <= {data_sync_q[0], Ps2Data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  // Frame state and datapath registers
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= FR_IDLE;
      shift_q <= 8'h00;
      cnt_q   <= 3'd0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state: shift bits on each falling edge, check parity/stop, abandon stalled frames
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    byte_d  = byte_q;

    if (state_q == FR_IDLE || fall) tmo_d = '0;
    else                            tmo_d = tmo_q + 1'b1;

    case (state_q)
      FR_IDLE: begin
        if (fall && !bit_in) begin
          state_d = FR_DATA;
          cnt_d   = 3'd0;
        end
      end
      FR_DATA: begin
        if (fall) begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = FR_PARITY;
        end
      end
      FR_PARITY: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = FR_STOP;
        end
      end
      FR_STOP: begin
        if (fall) begin
          state_d = FR_IDLE;
          if (bit_in && frame_parity_ok(shift_q, par_q)) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = FR_IDLE;
    endcase

    // A stalled partial frame is dropped silently; the error flag is left alone
    if (state_q != FR_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = FR_IDLE;
      tmo_d   = '0;
    end
  end

  assign ByteValid = valid_q;
  assign ByteData  = byte_q;
  assign FrameErr  = err_q;

endmodule

// File: rtl/pixo_key_input.sv
// rtl/pixo_key_input.sv - PS/2 keyboard peripheral: scan-code FIFO, STATUS/DATA/CTRL registers, optional IrqOut via KEYIN_IRQ_EN
module pixo_key_input
  import keyin_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       Clk,
  input  logic       ResetN,
  input  logic       Sel,
  input  logic [1:0] AdrIn,
  input  logic       LdMem,
  input  logic       WrtMem,
  input  logic [7:0] DataIn,
  output logic [7:0] DataOut,
`ifdef KEYIN_IRQ_EN
  output logic       IrqOut,
`endif
  input  logic       Ps2Clk,
  input  logic       Ps2Data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          irqe_q, irqe_d;
  logic [7:0]    dout_q, dout_d;
  logic [7:0]    rdata;

  reg_e          adr;
  logic          rd_req, ctrl_wr;
  logic          empty, full;
  logic          pop, push_ok, flush, clr, ovf_set;
  logic          unused_data;

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .Ps2Clk   (Ps2Clk),
    .Ps2Data  (Ps2Data),
    .ByteValid(byte_valid),
    .ByteData (byte_data),
    .FrameErr (frame_err)
  );

  assign adr     = reg_e'(AdrIn);
  assign rd_req  = Sel & LdMem;
  assign ctrl_wr = Sel & WrtMem & (adr == REG_CTRL);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_req & (adr == REG_DATA) & ~empty;
  assign flush   = ctrl_wr & DataIn[CTRL_FLUSH];
  assign clr     = ctrl_wr & DataIn[CTRL_CLR];
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign push_ok = byte_valid & (~full | pop) & ~flush;
  assign ovf_set = byte_valid & full & ~pop & ~flush;
  assign unused_data = ^DataIn[7:3];

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wptr_q] <= byte_data;
  end

  // Read mux for the currently addressed register
  always_comb begin
    rdata = 8'h00;
    case (adr)
      REG_STATUS: begin
        rdata[STAT_AVAIL] = ~empty;
        rdata[STAT_OVF]   = ovf_q;
        rdata[STAT_PERR]  = perr_q;
        rdata[STAT_FULL]  = full;
      end
      REG_DATA:   rdata = empty ? 8'h00 : mem[rptr_q];
      REG_CTRL:   rdata[CTRL_IRQE] = irqe_q;
      default:    rdata = 8'h00;
    endcase
  end

  // Next values for pointers, flags and the registered read port
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    irqe_d  = irqe_q;
    dout_d  = rd_req ? rdata : dout_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop)     rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end

    if (ctrl_wr) irqe_d = DataIn[CTRL_IRQE];

    // A fresh error on the clearing cycle keeps the flag set
    ovf_d  = (ovf_q  & ~clr) | ovf_set;
    perr_d = (perr_q & ~clr) | frame_err;
  end

  // Register state
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
      irqe_q  <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
      irqe_q  <= irqe_d;
      dout_q  <= dout_d;
    end
  end

  assign DataOut = dout_q;

`ifdef KEYIN_IRQ_EN
  logic irq_q;

  // Interrupt follows the enabled status condition one cycle later
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) irq_q <= 1'b0;
    else         irq_q <= irqe_q & (~empty | ovf_q | perr_q);
  end

  assign IrqOut = irq_q;
`endif

endmodule

// File: tb/tb_pixo_key_input.sv
// tb/tb_pixo_key_input.sv - self-checking bench for pixo_key_input
`timescale 1ns/1ps
module tb_pixo_key_input;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HP    = 10;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       Sel = 1'b0;
  logic [1:0] AdrIn = 2'd0;
  logic       LdMem = 1'b0;
  logic       WrtMem = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic [7:0] DataOut;
  logic       Ps2Clk = 1'b1;
  logic       Ps2Data = 1'b1;
`ifdef KEYIN_IRQ_EN
  logic       IrqOut;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_status;
  } vec_t;

  vec_t vecs[6];

  pixo_key_input #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Sel    (Sel),
    .AdrIn  (AdrIn),
    .LdMem  (LdMem),
    .WrtMem (WrtMem),
    .DataIn (DataIn),
    .DataOut(DataOut),
`ifdef KEYIN_IRQ_EN
    .IrqOut (IrqOut),
`endif
    .Ps2Clk (Ps2Clk),
    .Ps2Data(Ps2Data)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge Clk);
    Sel = 1'b1; LdMem = 1'b1; AdrIn = a;
    @(negedge Clk);
    Sel = 1'b0; LdMem = 1'b0;
    d = DataOut;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge Clk);
    Sel = 1'b1; WrtMem = 1'b1; AdrIn = a; DataIn = v;
    @(negedge Clk);
    Sel = 1'b0; WrtMem = 1'b0; DataIn = 8'h00;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Clk);
    Ps2Data = b;
    repeat (HP) @(negedge Clk);
    Ps2Clk = 1'b0;
    repeat (HP) @(negedge Clk);
    Ps2Clk = 1'b1;
  endtask

  task automatic sb_push(input logic [7:0] c);
    if (sb_q.size() < DEPTH) sb_q.push_back(c);
  endtask

  // Sends a whole frame; valid frames are posted to the scoreboard
  task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^c) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    repeat (6) @(negedge Clk);
    if (!bad_par && !bad_stop) sb_push(c);
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(2'd0, d);
    check(name, d, exp);
  endtask

  task automatic check_data(input string name);
    logic [7:0] d, e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    bus_read(2'd1, d);
    check(name, d, e);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] c;

    vecs[0] = '{code: 8'h1C, bad_par: 1'b0, bad_stop: 1'b0, exp_status: 8'h01};
    vecs[1] = '{code: 8'h1C, bad_par: 1'b1, bad_stop: 1'b0, exp_status: 8'h04};
    vecs[2] = '{code: 8'hA5, bad_par: 1'b0, bad_stop: 1'b1, exp_status: 8'h04};
    vecs[3] = '{code: 8'hF0, bad_par: 1'b0, bad_stop: 1'b0, exp_status: 8'h01};
    vecs[4] = '{code: 8'h00, bad_par: 1'b0, bad_stop: 1'b0, exp_status: 8'h01};
    vecs[5] = '{code: 8'hFF, bad_par: 1'b0, bad_stop: 1'b0, exp_status: 8'h01};

    repeat (3) @(negedge Clk);
    check("reset_dataout", DataOut, 8'h00);
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);
    check_status("reset_status", 8'h00);
    bus_read(2'd2, d);
    check("reset_ctrl", d, 8'h00);
`ifdef KEYIN_IRQ_EN
    check("reset_irq", {7'b0, IrqOut}, 8'h00);
`endif

    // Table-driven single frames
    foreach (vecs[i]) begin
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      check_status($sformatf("vec%0d_status", i), vecs[i].exp_status);
      if (vecs[i].exp_status[0]) begin
        check_data($sformatf("vec%0d_data", i));
        check_status($sformatf("vec%0d_status_after", i), 8'h00);
        repeat (5) @(negedge Clk);
        check($sformatf("vec%0d_hold", i), DataOut, 8'h00);
      end else begin
        bus_write(2'd2, 8'h01);
        check_status($sformatf("vec%0d_clr", i), 8'h00);
      end
    end

    // Overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_status("ovf_status", 8'h0B);
    for (int i = 0; i < 9; i++) check_data($sformatf("ovf_read%0d", i));
    check_status("ovf_empty_status", 8'h02);
    bus_write(2'd2, 8'h01);
    check_status("ovf_cleared", 8'h00);

    // Timeout drops a partial frame without raising PERR
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 20) @(negedge Clk);
    send_frame(8'hF0, 1'b0, 1'b0);
    check_status("tmo_status", 8'h01);
    check_data("tmo_data");
    check_status("tmo_status_after", 8'h00);

    // Flush empties the FIFO
    for (int i = 0; i < 3; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
    bus_write(2'd2, 8'h02);
    sb_q.delete();
    check_status("flush_status", 8'h00);
    check_data("flush_data");

    // Full FIFO with a DATA read landing on the frame-completion edge
    for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    check_status("full_status", 8'h09);
    c = 8'h99;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~(^c));
    @(negedge Clk);
    Ps2Data = 1'b1;
    repeat (HP) @(negedge Clk);
    Ps2Clk = 1'b0;
    repeat (3) @(negedge Clk);
    Sel = 1'b1; LdMem = 1'b1; AdrIn = 2'd1;
    @(negedge Clk);
    Sel = 1'b0; LdMem = 1'b0;
    check("race_read", DataOut, sb_q.pop_front());
    sb_q.push_back(c);
    repeat (HP) @(negedge Clk);
    Ps2Clk = 1'b1;
    repeat (6) @(negedge Clk);
    check_status("race_status", 8'h09);
    for (int i = 0; i < DEPTH; i++) check_data($sformatf("race_drain%0d", i));
    check_status("race_empty", 8'h00);

    // Reserved offset and CTRL readback
    bus_read(2'd3, d);
    check("rsvd_read", d, 8'h00);
    bus_write(2'd2, 8'h04);
    bus_read(2'd2, d);
    check("ctrl_irqe_read", d, 8'h04);

    // Reset pulse in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge Clk);
    ResetN = 1'b0;
    sb_q.delete();
    @(negedge Clk);
    check("midreset_dataout", DataOut, 8'h00);
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);
    bus_read(2'd2, d);
    check("midreset_irqe", d, 8'h00);
    bus_write(2'd2, 8'h04);
    send_frame(8'h5A, 1'b0, 1'b0);
    check_status("midreset_status", 8'h01);
`ifdef KEYIN_IRQ_EN
    check("irq_high", {7'b0, IrqOut}, 8'h01);
`endif
    check_data("midreset_data");
    @(negedge Clk);
`ifdef KEYIN_IRQ_EN
    check("irq_low", {7'b0, IrqOut}, 8'h00);
`endif
    check_status("final_status", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
